noc_flit_packetizer: RTL and testbench

- Write-side producer for the NoC clock-domain-crossing flit FIFO.
- Accepts a packet request (destination, length) plus a stream of payload words. Emits a head flit followed by body/tail flits on the FIFO write port (wren/wdata), honouring the FIFO's wfull backpressure.
- Sits in the router's injection port, in the wclk domain, directly in front of the async FIFO.

---
 rtl/noc_flit_packetizer_if.sv | 30 +++
 rtl/noc_flit_packetizer.sv | 118 +++++++++++
 tb/tb_noc_flit_packetizer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_flit_packetizer_if.sv
// Injection-port bundle between the packet source, the packetizer and the write side of the CDC flit FIFO.
interface noc_flit_packetizer_if #(
  parameter int unsigned PAYLOAD_W = 32,
  parameter int unsigned LEN_W     = 4
);
  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [3:0]           pkt_dest;
  logic [LEN_W-1:0]     pkt_len;
  logic                 data_valid;
  logic                 data_ready;
  logic [PAYLOAD_W-1:0] data_in;
  logic                 wfull;
  logic                 wren;
  logic [PAYLOAD_W+1:0] wdata;
  logic                 busy;
  logic [7:0]           seq_id;

  // Environment side: packet source plus FIFO full flag.
  modport master (
    output pkt_valid, pkt_dest, pkt_len, data_valid, data_in, wfull,
    input  pkt_ready, data_ready, wren, wdata, busy, seq_id
  );

  // Packetizer side.
  modport slave (
    input  pkt_valid, pkt_dest, pkt_len, data_valid, data_in, wfull,
    output pkt_ready, data_ready, wren, wdata, busy, seq_id
  );
endinterface

// File: rtl/noc_flit_packetizer.sv
// Write-domain packetizer: turns a (dest, len) request plus payload words into
// HEAD / BODY / TAIL flits on the async FIFO write port, honouring wfull.
module noc_flit_packetizer #(
  parameter int unsigned PAYLOAD_W = 32,
  parameter int unsigned LEN_W     = 4,
  parameter logic [3:0]  SRC_ID    = 4'h0
) (
  input  logic                  wclk,
  input  logic                  wrstn,
  noc_flit_packetizer_if.slave  io_bus
);
  localparam int unsigned FLIT_W = PAYLOAD_W + 2;
  localparam int unsigned HDR_W  = 24;

  localparam logic [1:0] TYPE_BODY     = 2'b00;
  localparam logic [1:0] TYPE_HEAD     = 2'b01;
  localparam logic [1:0] TYPE_TAIL     = 2'b10;
  localparam logic [1:0] TYPE_HEADTAIL = 2'b11;

  if (PAYLOAD_W < HDR_W) begin : g_bad_payload_w
    $error("noc_flit_packetizer: PAYLOAD_W must be >= 24");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_flit_vld;
  logic [LEN_W-1:0]     r_remaining;
  logic [7:0]           r_seq_id;
  logic [FLIT_W-1:0]    r_wdata;

  logic                 w_flit_accept;
  logic                 w_pkt_ready;
  logic                 w_data_ready;
  logic                 w_pkt_hs;
  logic                 w_data_hs;
  logic                 w_last_data;
  logic                 w_tail_pending;
  logic [PAYLOAD_W-1:0] w_head_payload;

  assign w_flit_accept  = r_flit_vld && !io_bus.wfull;
  assign w_pkt_hs       = io_bus.pkt_valid && w_pkt_ready;
  assign w_data_hs      = io_bus.data_valid && w_data_ready;
  assign w_last_data    = (r_remaining == LEN_W'(1));
  assign w_tail_pending = (r_wdata[FLIT_W-1:PAYLOAD_W] == TYPE_TAIL);

  // Head payload: dest, source, length, sequence number packed at the top; low bits zero.
  always_comb begin
    w_head_payload = '0;
    w_head_payload[PAYLOAD_W-1 -: HDR_W] = {io_bus.pkt_dest, SRC_ID, 8'(io_bus.pkt_len), r_seq_id};
  end

  // State register.
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: leave HEAD/BODY only once the final flit of the packet is taken by the FIFO.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_pkt_hs) w_state_nxt = S_HEAD;
      S_HEAD: if (w_flit_accept) w_state_nxt = (r_remaining == '0) ? S_IDLE : S_BODY;
      S_BODY: if (w_flit_accept && w_tail_pending) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs: a new payload word is taken only when the holding register is free or draining.
  always_comb begin
    w_pkt_ready  = 1'b0;
    w_data_ready = 1'b0;
    case (r_state)
      S_IDLE: w_pkt_ready  = 1'b1;
      S_HEAD: w_data_ready = (r_remaining != '0) && w_flit_accept;
      S_BODY: w_data_ready = (r_remaining != '0) && (!r_flit_vld || w_flit_accept);
      default: ;
    endcase
  end

  // Flit holding register, remaining-word counter and sequence number.
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      r_wdata     <= '0;
      r_flit_vld  <= 1'b0;
      r_remaining <= '0;
      r_seq_id    <= '0;
    end else if (w_pkt_hs) begin
      r_wdata     <= {(io_bus.pkt_len == '0) ? TYPE_HEADTAIL : TYPE_HEAD, w_head_payload};
      r_flit_vld  <= 1'b1;
      r_remaining <= io_bus.pkt_len;
      r_seq_id    <= r_seq_id + 8'd1;
    end else if (w_data_hs) begin
      r_wdata     <= {w_last_data ? TYPE_TAIL : TYPE_BODY, io_bus.data_in};
      r_flit_vld  <= 1'b1;
      r_remaining <= r_remaining - LEN_W'(1);
    end else if (w_flit_accept) begin
      r_flit_vld  <= 1'b0;
    end
  end

  assign io_bus.wren       = w_flit_accept;
  assign io_bus.wdata      = r_wdata;
  assign io_bus.pkt_ready  = w_pkt_ready;
  assign io_bus.data_ready = w_data_ready;
  assign io_bus.busy       = (r_state != S_IDLE);
  assign io_bus.seq_id     = r_seq_id;

endmodule

// File: tb/tb_noc_flit_packetizer.sv
// Directed bench for noc_flit_packetizer: header format, flow control, stalls, reset and sequence wrap.
module tb_noc_flit_packetizer;
  localparam int unsigned PW  = 32;
  localparam int unsigned LW  = 4;
  localparam logic [3:0]  SRC = 4'h2;

  logic wclk  = 1'b0;
  logic wrstn = 1'b1;
  always #5 wclk = ~wclk;

  noc_flit_packetizer_if #(.PAYLOAD_W(PW), .LEN_W(LW)) bus ();

  noc_flit_packetizer #(.PAYLOAD_W(PW), .LEN_W(LW), .SRC_ID(SRC)) dut (
    .wclk  (wclk),
    .wrstn (wrstn),
    .io_bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit phase  = 1'b0;
  bit gap_en = 1'b0;

  logic [PW+1:0] flit_q[$];
  int            flit_cyc_q[$];
  logic [PW-1:0] data_q[$];

  // One clock: capture FIFO writes at negedge, then advance the payload source after posedge.
  task automatic tick();
    bit hs;
    @(negedge wclk);
    hs = (bus.data_valid === 1'b1) && (bus.data_ready === 1'b1);
    if (bus.wren === 1'b1) begin
      flit_q.push_back(bus.wdata);
      flit_cyc_q.push_back(cyc);
    end
    @(posedge wclk);
    #1;
    cyc++;
    if (hs && data_q.size() > 0) void'(data_q.pop_front());
    phase = !phase;
    if (data_q.size() > 0 && !(gap_en && phase)) begin
      bus.data_valid = 1'b1;
      bus.data_in    = data_q[0];
    end else begin
      bus.data_valid = 1'b0;
    end
  endtask

  task automatic send_pkt(input logic [3:0] dest, input logic [LW-1:0] len, output bit ok);
    bus.pkt_valid = 1'b1;
    bus.pkt_dest  = dest;
    bus.pkt_len   = len;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (bus.pkt_ready === 1'b1) ok = 1'b1;
      tick();
    end
    bus.pkt_valid = 1'b0;
  endtask

  task automatic wait_flits(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (flit_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic flush();
    flit_q.delete();
    flit_cyc_q.delete();
    data_q.delete();
  endtask

  task automatic test_reset();
    wrstn = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (bus.wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", bus.wren); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.seq_id !== 8'h00) begin errors++; $display("FAIL reset_seq: got %h expected 00", bus.seq_id); end
    checks++; if (bus.wdata !== 34'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.wdata); end
    checks++; if (bus.pkt_ready !== 1'b1) begin errors++; $display("FAIL reset_pkt_ready: got %b expected 1", bus.pkt_ready); end
    checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b expected 0", bus.data_ready); end
    #1 wrstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int c0;
    logic [PW+1:0] exp[4];
    exp = '{{2'b01, 32'h5203_0000}, {2'b00, 32'hA1}, {2'b00, 32'hA2}, {2'b10, 32'hA3}};
    flush();
    data_q.push_back(32'hA1); data_q.push_back(32'hA2); data_q.push_back(32'hA3);
    send_pkt(4'h5, 4'd3, ok);
    c0 = cyc;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_pkt_hs: got %b expected 1", ok); end
    wait_flits(4, 20, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_flit_count: got %0d expected 4", flit_q.size()); end
    if (flit_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (flit_q[k] !== exp[k]) begin errors++; $display("FAIL basic_flit%0d: got %h expected %h", k, flit_q[k], exp[k]); end
      end
      checks++; if (flit_cyc_q[0] !== c0) begin errors++; $display("FAIL basic_head_latency: got cycle %0d expected %0d", flit_cyc_q[0], c0); end
      checks++; if (flit_cyc_q[3] !== c0 + 3) begin errors++; $display("FAIL basic_tail_cycle: got cycle %0d expected %0d", flit_cyc_q[3], c0 + 3); end
    end
    #1;
    checks++; if (bus.seq_id !== 8'h01) begin errors++; $display("FAIL basic_seq: got %h expected 01", bus.seq_id); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_headtail();
    bit ok;
    flush();
    send_pkt(4'hA, 4'd0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ht_pkt_hs: got %b expected 1", ok); end
    #1;
    checks++; if (bus.wren !== 1'b1) begin errors++; $display("FAIL ht_wren: got %b expected 1", bus.wren); end
    checks++; if (bus.wdata !== {2'b11, 32'hA200_0100}) begin errors++; $display("FAIL ht_flit: got %h expected %h", bus.wdata, {2'b11, 32'hA200_0100}); end
    tick();
    #1;
    checks++; if (bus.pkt_ready !== 1'b1) begin errors++; $display("FAIL ht_pkt_ready_next: got %b expected 1", bus.pkt_ready); end
    checks++; if (bus.wren !== 1'b0) begin errors++; $display("FAIL ht_single_write: got %b expected 0", bus.wren); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [PW+1:0] exp[5];
    exp = '{{2'b01, 32'h3204_0200}, {2'b00, 32'hB1}, {2'b00, 32'hB2}, {2'b00, 32'hB3}, {2'b10, 32'hB4}};
    flush();
    data_q.push_back(32'hB1); data_q.push_back(32'hB2); data_q.push_back(32'hB3); data_q.push_back(32'hB4);
    send_pkt(4'h3, 4'd4, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_pkt_hs: got %b expected 1", ok); end
    tick();
    tick();
    bus.wfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.wren !== 1'b0) begin errors++; $display("FAIL stall_wren%0d: got %b expected 0", k, bus.wren); end
      checks++; if (bus.wdata !== {2'b00, 32'hB2}) begin errors++; $display("FAIL stall_wdata%0d: got %h expected %h", k, bus.wdata, {2'b00, 32'hB2}); end
      checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL stall_data_ready%0d: got %b expected 0", k, bus.data_ready); end
      tick();
    end
    bus.wfull = 1'b0;
    wait_flits(5, 20, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_flit_count: got %0d expected 5", flit_q.size()); end
    if (flit_q.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (flit_q[k] !== exp[k]) begin errors++; $display("FAIL stall_flit%0d: got %h expected %h", k, flit_q[k], exp[k]); end
      end
    end
  endtask

  task automatic test_gaps();
    bit ok;
    logic [PW+1:0] exp[5];
    exp = '{{2'b01, 32'h6204_0300}, {2'b00, 32'hC1}, {2'b00, 32'hC2}, {2'b00, 32'hC3}, {2'b10, 32'hC4}};
    flush();
    gap_en = 1'b1;
    data_q.push_back(32'hC1); data_q.push_back(32'hC2); data_q.push_back(32'hC3); data_q.push_back(32'hC4);
    send_pkt(4'h6, 4'd4, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL gap_pkt_hs: got %b expected 1", ok); end
    wait_flits(5, 40, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL gap_flit_count: got %0d expected 5", flit_q.size()); end
    if (flit_q.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (flit_q[k] !== exp[k]) begin errors++; $display("FAIL gap_flit%0d: got %h expected %h", k, flit_q[k], exp[k]); end
      end
      checks++; if (flit_cyc_q[4] - flit_cyc_q[0] <= 4) begin errors++; $display("FAIL gap_bubbles: got span %0d expected >4", flit_cyc_q[4] - flit_cyc_q[0]); end
    end
    tick();
    checks++; if (flit_q.size() !== 5) begin errors++; $display("FAIL gap_extra_flits: got %0d expected 5", flit_q.size()); end
    gap_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    flush();
    for (int k = 1; k <= 5; k++) data_q.push_back(32'hD0 + 32'(k));
    send_pkt(4'h7, 4'd5, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmid_pkt_hs: got %b expected 1", ok); end
    wait_flits(3, 20, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmid_progress: got %0d expected 3", flit_q.size()); end
    wrstn = 1'b0;
    #1;
    checks++; if (bus.wren !== 1'b0) begin errors++; $display("FAIL rmid_wren: got %b expected 0", bus.wren); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.seq_id !== 8'h00) begin errors++; $display("FAIL rmid_seq: got %h expected 00", bus.seq_id); end
    flush();
    #1 wrstn = 1'b1;
    tick();
    data_q.push_back(32'hE1);
    send_pkt(4'h8, 4'd1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmid_next_hs: got %b expected 1", ok); end
    wait_flits(2, 20, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmid_next_count: got %0d expected 2", flit_q.size()); end
    if (flit_q.size() >= 2) begin
      checks++; if (flit_q[0] !== {2'b01, 32'h8201_0000}) begin errors++; $display("FAIL rmid_next_head: got %h expected %h", flit_q[0], {2'b01, 32'h8201_0000}); end
      checks++; if (flit_q[1] !== {2'b10, 32'hE1}) begin errors++; $display("FAIL rmid_next_tail: got %h expected %h", flit_q[1], {2'b10, 32'hE1}); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [PW+1:0] exp;
    logic [7:0] seq;
    wrstn = 1'b0;
    tick();
    #1 wrstn = 1'b1;
    tick();
    flush();
    bus.pkt_valid = 1'b1;
    bus.pkt_dest  = 4'h1;
    bus.pkt_len   = 4'd0;
    wait_flits(257, 700, ok);
    bus.pkt_valid = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_count: got %0d expected 257", flit_q.size()); end
    if (flit_q.size() >= 257) begin
      for (int i = 0; i < 257; i++) begin
        seq = 8'(i);
        exp = {2'b11, 4'h1, SRC, 8'h00, seq, 8'h00};
        checks++; if (flit_q[i] !== exp) begin errors++; $display("FAIL b2b_flit%0d: got %h expected %h", i, flit_q[i], exp); end
        if (i > 0) begin
          checks++; if (flit_cyc_q[i] - flit_cyc_q[i-1] !== 2) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected 2", i, flit_cyc_q[i] - flit_cyc_q[i-1]); end
        end
      end
    end
    tick();
    #1;
    checks++; if (bus.seq_id !== 8'h01) begin errors++; $display("FAIL b2b_seq_wrap: got %h expected 01", bus.seq_id); end
    checks++; if (flit_q.size() !== 257) begin errors++; $display("FAIL b2b_extra: got %0d expected 257", flit_q.size()); end
  endtask

  initial begin
    bus.pkt_valid  = 1'b0;
    bus.pkt_dest   = 4'h0;
    bus.pkt_len    = '0;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    bus.wfull      = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_headtail();
    test_stall();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
